fsm_par_join: RTL

Parallel-composition control FSM for generated Calyx simulation netlists. It sits directly upstream of the per-group enable FSMs, in the same position a sequential controller occupies. It launches N child enable FSMs concurrently from one parent `valid`, records each child's `ready` in a sticky done bit, and raises its own `ready` once every child has finished. It lets `par { ... }` blocks drive the same enable FSMs that sequential blocks drive.

---
 rtl/calyx_fsm_pkg.sv | 14 +
 rtl/calyx_watchdog.sv | 31 +++
 rtl/fsm_par_join.sv | 115 +++++++++++
 3 files changed

// File: rtl/calyx_fsm_pkg.sv
// Shared types and handshake constants for the Calyx control FSMs
// (sequential, enable and parallel-join controllers).
package calyx_fsm_pkg;

    typedef enum logic [1:0] {
        PAR_IDLE = 2'd0,
        PAR_RUN  = 2'd1,
        PAR_DONE = 2'd2
    } par_state_e;

    localparam logic HS_ON  = 1'b1;
    localparam logic HS_OFF = 1'b0;

endpackage

// File: rtl/calyx_watchdog.sv
// Run-time watchdog for the parallel-join FSM: counts cycles while enabled
// and flags expiry on the WDOG_CYCLES-th enabled cycle.
module calyx_watchdog #(
    parameter int WDOG_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int W = $clog2(WDOG_CYCLES + 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_en && (count_reg != W'(WDOG_CYCLES))) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // The first enabled cycle sees a count of 0, so expiry on WDOG_CYCLES-1
    // limits the enabled window to exactly WDOG_CYCLES cycles.
    assign expired = count_en && (count_reg == W'(WDOG_CYCLES - 1));

endmodule

// File: rtl/fsm_par_join.sv
// Parallel-composition control FSM: launches N child enable FSMs together and
// reports ready once all have finished. Optional watchdog: CALYX_PAR_WATCHDOG_EN.
module fsm_par_join
    import calyx_fsm_pkg::*;
#(
    parameter int N           = 2,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid,
    input  logic [N-1:0] ready_child,
    output logic         ready,
    output logic [N-1:0] valid_child,
    output logic         error
);

    par_state_e   state_reg;
    par_state_e   state_next;
    logic [N-1:0] done_q;
    logic [N-1:0] done_next;
    logic         err_q;
    logic         err_next;
    logic         wdog_expired;

`ifdef CALYX_PAR_WATCHDOG_EN
    calyx_watchdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_reg != PAR_RUN),
        .count_en (state_reg == PAR_RUN),
        .expired  (wdog_expired)
    );
`else
    // No watchdog: expiry can never fire, so RUN waits for the children.
    assign wdog_expired = HS_OFF & (WDOG_CYCLES == 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= PAR_IDLE;
            done_q    <= '0;
            err_q     <= HS_OFF;
        end else begin
            state_reg <= state_next;
            done_q    <= done_next;
            err_q     <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = done_q;
        err_next   = err_q;
        case (state_reg)
            PAR_IDLE: begin
                err_next = HS_OFF;
                if (valid) begin
                    state_next = PAR_RUN;
                    done_next  = '0;
                end
            end
            PAR_RUN: begin
                // Parent abort wins over completion and over watchdog expiry.
                if (!valid) begin
                    state_next = PAR_IDLE;
                    done_next  = '0;
                end else if (&(done_q | ready_child)) begin
                    state_next = PAR_DONE;
                    done_next  = done_q | ready_child;
                    err_next   = HS_OFF;
                end else if (wdog_expired) begin
                    state_next = PAR_DONE;
                    err_next   = HS_ON;
                end else begin
                    done_next = done_q | ready_child;
                end
            end
            PAR_DONE: begin
                if (!valid) begin
                    state_next = PAR_IDLE;
                    err_next   = HS_OFF;
                end
            end
            default: begin
                state_next = PAR_IDLE;
                done_next  = '0;
                err_next   = HS_OFF;
            end
        endcase
    end

    always_comb begin
        ready       = HS_OFF;
        valid_child = '0;
        error       = HS_OFF;
        case (state_reg)
            PAR_RUN: begin
                valid_child = ~done_q;
            end
            PAR_DONE: begin
                ready = HS_ON;
                error = err_q;
            end
            default: begin
                ready       = HS_OFF;
                valid_child = '0;
                error       = HS_OFF;
            end
        endcase
    end

endmodule
